serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor. Computes diff = a - b - b_in.
//   Processes one bit per clock, LSB first, with a registered borrow.
//   Takes operands on a start/ready handshake and returns a one-cycle done pulse
//   with the difference, the borrow-out and the signed-overflow flag.
//   Serves as the subtract datapath for multi-cycle arithmetic units; chain via b_in/b_out.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (legal range >= 2)
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only while ready=1
//   a      in   WIDTH  minuend, sampled with start
//   b      in   WIDTH  subtrahend, sampled with start
//   b_in   in   1      borrow-in, sampled with start
//   ready  out  1      high in IDLE only
//   done   out  1      one-cycle pulse; results valid while high and held afterwards
//   diff   out  WIDTH  a - b - b_in, modulo 2^WIDTH
//   b_out  out  1      borrow-out: 1 iff unsigned a < b + b_in
//   ovf    out  1      signed overflow of a - b - b_in
// BEHAVIOUR
//   Reset values: ready=1, done=0, diff=0, b_out=0, ovf=0; state=IDLE, bit counter=0.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: ready=1. On start=1 at an edge:
//     - latch a and b into shift registers and b_in into the borrow flop
//     - clear the counter
//     - go to RUN
//   RUN: ready=0. On each edge, with x=a_sh[0], y=b_sh[0], br=borrow:
//     - d = x^y^br
//     - br' = (~x&y) | (~(x^y)&br)
//     - shift d into the result MSB (shift right); shift both operands right; counter++
//     - On the edge that processes bit WIDTH-1, also:
//       - b_out <= br'
//       - ovf <= (x != y) && (d != x)
//       - go to DONE
//   DONE: done=1 and ready=0 for exactly one cycle; next edge goes to IDLE.
//   Latency: start sampled at edge E0; done high in the cycle after edge E(WIDTH).
//     - ready returns after E(WIDTH+1)
//     - with start held high, back-to-back issue interval is WIDTH+2 cycles
//   diff, b_out and ovf:
//     - hold their values from DONE until the next DONE or reset
//     - are updated only on the final RUN edge (the result register is internal)
//     - do not show partial values
//   start while ready=0 (RUN or DONE) is ignored; no queuing; operands/b_in changes are ignored.
//   rst mid-operation: the next edge forces IDLE and reset values; the in-flight op is
//     discarded with no done pulse. rst has priority over start in the same cycle.
//   Width: the counter is $clog2(WIDTH) bits; no internal widening; results wrap modulo 2^WIDTH.
// TESTING (WIDTH=8)
//   1. a=8'h5A b=8'h23 b_in=0 -> diff=8'h37 b_out=0 ovf=0; done 1 cycle, 8 cycles after start edge
//   2. a=8'h00 b=8'h01 b_in=0 -> diff=8'hFF b_out=1 ovf=0; a=8'h80 b=8'h01 -> diff=8'h7F b_out=0 ovf=1
//   3. a=8'h7F b=8'hFF b_in=0 -> diff=8'h80 b_out=1 ovf=1; a=8'h10 b=8'h10 b_in=1 -> diff=8'hFF b_out=1 ovf=0
//   4. Start a=8'h05 b=8'h03, then pulse start with a=8'hAA b=8'h11 during RUN -> single done, diff=8'h02
//   5. rst at 4th RUN cycle -> next cycle ready=1 done=0 diff=0; no done pulse; a=8'h09 b=8'h04 then gives diff=8'h05
//   6. start held high over 3 ops -> done pulses exactly 10 cycles apart; each result matches the reference model
//   Plus a random sweep (>=1000 ops, random b_in) checked against {b_out,diff} = {1'b0,a} - b - b_in.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start/ready request side
// plus the done-qualified difference, borrow-out and overflow flags.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  ready, done, diff, b_out, ovf
    );

    modport slave (
        input  start, a, b, b_in,
        output ready, done, diff, b_out, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, one bit per clock,
// LSB first, with a registered borrow. Chain wide operations via b_in/b_out.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;

    logic             x_c;
    logic             y_c;
    logic             d_c;
    logic             br_nxt_c;
    logic             last_bit_c;
    logic [WIDTH-1:0] res_nxt_c;

    // Single full-subtractor cell applied to the current LSBs
    always_comb begin
        x_c        = a_sh[0];
        y_c        = b_sh[0];
        d_c        = x_c ^ y_c ^ borrow;
        br_nxt_c   = (~x_c & y_c) | (~(x_c ^ y_c) & borrow);
        last_bit_c = (cnt == CNT_W'(WIDTH - 1));
        res_nxt_c  = {d_c, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_RUN;
            S_RUN:  if (last_bit_c) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; visible results change only on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            bus.diff  <= '0;
            bus.b_out <= 1'b0;
            bus.ovf   <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            borrow    <= 1'b0;
        end else begin
            bus.ready <= (state_nxt == S_IDLE);
            bus.done  <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= bus.b_in;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt_c;
                    borrow <= br_nxt_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit_c) begin
                        bus.diff  <= res_nxt_c;
                        bus.b_out <= br_nxt_c;
                        bus.ovf   <= (x_c != y_c) && (d_c != x_c);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
